// File: rtl/rename_alloc_ctrl_pkg.sv
// rtl/rename_alloc_ctrl_pkg.sv - shared sizes and helpers for the rename allocator
package rename_alloc_ctrl_pkg;
  localparam int ROB_SIZE = 32;
  localparam int ROB_W    = $clog2(ROB_SIZE);
  localparam int NUM_GPR  = 32;
  localparam int GPR_W    = $clog2(NUM_GPR);

  // True when a nonzero source reads the GPR that an earlier slot writes.
  function automatic logic dep_hit(input logic [GPR_W-1:0] src,
                                   input logic [GPR_W-1:0] dst,
                                   input logic             wr);
    return wr && (src != '0) && (src == dst);
  endfunction
endpackage

// File: rtl/rename_src_resolve.sv
// rtl/rename_src_resolve.sv - resolve one source operand to producer number and busy bit
module rename_src_resolve
  import rename_alloc_ctrl_pkg::*;
(
  input  logic [GPR_W-1:0] src,
  input  logic [ROB_W-1:0] tbl_num,
  input  logic             tbl_busy,
  input  logic [GPR_W-1:0] prod_dst,
  input  logic             prod_valid,
  input  logic [ROB_W-1:0] prod_num,
  output logic [ROB_W-1:0] num,
  output logic             busy
);
  always_comb begin
    num  = tbl_num;
    busy = tbl_busy;
    if (src == '0) begin
      num  = '0;
      busy = 1'b0;
    end else if (prod_valid && (src == prod_dst)) begin
      num  = prod_num;
      busy = 1'b1;
    end
  end
endmodule

// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - two-wide rename: ROB allocation, GPR table sequencing, dispatch register
// Macro RENAME_BYPASS_EN: forward slot-0 destination into slot-1 sources instead of splitting the pair.
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic [GPR_W-1:0] in_src0a,
  input  logic [GPR_W-1:0] in_src0b,
  input  logic [GPR_W-1:0] in_src1a,
  input  logic [GPR_W-1:0] in_src1b,
  input  logic [GPR_W-1:0] in_dst0,
  input  logic [GPR_W-1:0] in_dst1,
  input  logic             in_wen0,
  input  logic             in_wen1,
  output logic             in_acc0,
  output logic             in_acc1,
  output logic [GPR_W-1:0] tbl_raddr0,
  output logic [GPR_W-1:0] tbl_raddr1,
  output logic [GPR_W-1:0] tbl_raddr2,
  output logic [GPR_W-1:0] tbl_raddr3,
  input  logic [ROB_W-1:0] tbl_rnum0,
  input  logic [ROB_W-1:0] tbl_rnum1,
  input  logic [ROB_W-1:0] tbl_rnum2,
  input  logic [ROB_W-1:0] tbl_rnum3,
  input  logic             tbl_rbusy0,
  input  logic             tbl_rbusy1,
  input  logic             tbl_rbusy2,
  input  logic             tbl_rbusy3,
  output logic [GPR_W-1:0] tbl_waddr0,
  output logic [GPR_W-1:0] tbl_waddr1,
  output logic             tbl_wen0,
  output logic             tbl_wen1,
  output logic [ROB_W-1:0] tbl_wnum0,
  output logic [ROB_W-1:0] tbl_wnum1,
  input  logic [1:0]       commit_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_v1,
  output logic [ROB_W-1:0] out_rob0,
  output logic [ROB_W-1:0] out_rob1,
  output logic [ROB_W-1:0] out_num0a,
  output logic [ROB_W-1:0] out_num0b,
  output logic [ROB_W-1:0] out_num1a,
  output logic [ROB_W-1:0] out_num1b,
  output logic             out_busy0a,
  output logic             out_busy0b,
  output logic             out_busy1a,
  output logic             out_busy1b
);
  logic [ROB_W-1:0] tail;
  logic [ROB_W:0]   free;
  logic             stg_rdy, dep_ok, wr0, wr1, byp_valid;
  logic [ROB_W-1:0] rob0, rob1;
  logic [ROB_W:0]   n_acc, n_commit;
  logic [ROB_W-1:0] num0a, num0b, num1a, num1b;
  logic             busy0a, busy0b, busy1a, busy1b;

  assign stg_rdy = ~out_valid | out_ready;
  assign wr0     = in_wen0 & (in_dst0 != '0);
  assign wr1     = in_wen1 & (in_dst1 != '0);

`ifdef RENAME_BYPASS_EN
  assign dep_ok    = 1'b1;
  assign byp_valid = wr0;
`else
  // Without forwarding, a dependent slot 1 waits a cycle so it reads the table after slot 0 writes it.
  assign dep_ok    = ~(dep_hit(in_src1a, in_dst0, wr0) | dep_hit(in_src1b, in_dst0, wr0));
  assign byp_valid = 1'b0;
`endif

  assign in_acc0  = in_valid0 & stg_rdy & (free != '0) & ~flush;
  assign in_acc1  = in_acc0 & in_valid1 & (free >= (ROB_W+1)'(2)) & dep_ok;
  assign rob0     = tail;
  assign rob1     = tail + ROB_W'(1);
  assign n_acc    = (ROB_W+1)'(in_acc0) + (ROB_W+1)'(in_acc1);
  assign n_commit = (ROB_W+1)'(commit_cnt);

  assign tbl_raddr0 = in_src0a;
  assign tbl_raddr1 = in_src0b;
  assign tbl_raddr2 = in_src1a;
  assign tbl_raddr3 = in_src1b;
  assign tbl_wen0   = in_acc0 & wr0;
  assign tbl_wen1   = in_acc1 & wr1;
  assign tbl_waddr0 = in_dst0;
  assign tbl_waddr1 = in_dst1;
  assign tbl_wnum0  = rob0;
  assign tbl_wnum1  = rob1;

  rename_src_resolve u_res0a (.src(in_src0a), .tbl_num(tbl_rnum0), .tbl_busy(tbl_rbusy0),
    .prod_dst('0), .prod_valid(1'b0), .prod_num('0), .num(num0a), .busy(busy0a));
  rename_src_resolve u_res0b (.src(in_src0b), .tbl_num(tbl_rnum1), .tbl_busy(tbl_rbusy1),
    .prod_dst('0), .prod_valid(1'b0), .prod_num('0), .num(num0b), .busy(busy0b));
  rename_src_resolve u_res1a (.src(in_src1a), .tbl_num(tbl_rnum2), .tbl_busy(tbl_rbusy2),
    .prod_dst(in_dst0), .prod_valid(byp_valid), .prod_num(rob0), .num(num1a), .busy(busy1a));
  rename_src_resolve u_res1b (.src(in_src1b), .tbl_num(tbl_rnum3), .tbl_busy(tbl_rbusy3),
    .prod_dst(in_dst0), .prod_valid(byp_valid), .prod_num(rob0), .num(num1b), .busy(busy1b));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail       <= '0;
      free       <= (ROB_W+1)'(ROB_SIZE);
      out_valid  <= 1'b0;
      out_v1     <= 1'b0;
      out_rob0   <= '0;
      out_rob1   <= '0;
      out_num0a  <= '0;
      out_num0b  <= '0;
      out_num1a  <= '0;
      out_num1b  <= '0;
      out_busy0a <= 1'b0;
      out_busy0b <= 1'b0;
      out_busy1a <= 1'b0;
      out_busy1b <= 1'b0;
    end else if (flush) begin
      tail      <= '0;
      free      <= (ROB_W+1)'(ROB_SIZE);
      out_valid <= 1'b0;
    end else begin
      tail <= tail + n_acc[ROB_W-1:0];
      free <= free - n_acc + n_commit;
      if (in_acc0) begin
        out_valid  <= 1'b1;
        out_v1     <= in_acc1;
        out_rob0   <= rob0;
        out_rob1   <= rob1;
        out_num0a  <= num0a;
        out_num0b  <= num0b;
        out_num1a  <= num1a;
        out_num1b  <= num1b;
        out_busy0a <= busy0a;
        out_busy0b <= busy0b;
        out_busy1a <= busy1a;
        out_busy1b <= busy1b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb/tb_rename_alloc_ctrl.sv - randomized self-checking bench for rename_alloc_ctrl
module tb_rename_alloc_ctrl;
  import rename_alloc_ctrl_pkg::*;

`ifdef RENAME_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, in_valid0, in_valid1, in_wen0, in_wen1, out_ready;
  logic [GPR_W-1:0] in_src0a, in_src0b, in_src1a, in_src1b, in_dst0, in_dst1;
  logic [1:0] commit_cnt;
  logic in_acc0, in_acc1, tbl_wen0, tbl_wen1;
  logic [GPR_W-1:0] tbl_raddr0, tbl_raddr1, tbl_raddr2, tbl_raddr3, tbl_waddr0, tbl_waddr1;
  logic [ROB_W-1:0] tbl_rnum0, tbl_rnum1, tbl_rnum2, tbl_rnum3, tbl_wnum0, tbl_wnum1;
  logic tbl_rbusy0, tbl_rbusy1, tbl_rbusy2, tbl_rbusy3;
  logic out_valid, out_v1, out_busy0a, out_busy0b, out_busy1a, out_busy1b;
  logic [ROB_W-1:0] out_rob0, out_rob1, out_num0a, out_num0b, out_num1a, out_num1b;

  // GPR status table lives in the bench and answers the four source lookups.
  logic [ROB_W-1:0] tnum [NUM_GPR];
  logic             tbusy[NUM_GPR];
  assign tbl_rnum0  = tnum[in_src0a];
  assign tbl_rnum1  = tnum[in_src0b];
  assign tbl_rnum2  = tnum[in_src1a];
  assign tbl_rnum3  = tnum[in_src1b];
  assign tbl_rbusy0 = tbusy[in_src0a];
  assign tbl_rbusy1 = tbusy[in_src0b];
  assign tbl_rbusy2 = tbusy[in_src1a];
  assign tbl_rbusy3 = tbusy[in_src1b];

  int checks = 0;
  int errors = 0;
  int tail_m;
  int rob_q[$];
  logic ov_m, v1_m;
  logic [ROB_W-1:0] m_rob0, m_rob1;
  logic [ROB_W:0]   m_src[4];

  rename_alloc_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_src0a(in_src0a), .in_src0b(in_src0b), .in_src1a(in_src1a), .in_src1b(in_src1b),
    .in_dst0(in_dst0), .in_dst1(in_dst1), .in_wen0(in_wen0), .in_wen1(in_wen1),
    .in_acc0(in_acc0), .in_acc1(in_acc1),
    .tbl_raddr0(tbl_raddr0), .tbl_raddr1(tbl_raddr1), .tbl_raddr2(tbl_raddr2), .tbl_raddr3(tbl_raddr3),
    .tbl_rnum0(tbl_rnum0), .tbl_rnum1(tbl_rnum1), .tbl_rnum2(tbl_rnum2), .tbl_rnum3(tbl_rnum3),
    .tbl_rbusy0(tbl_rbusy0), .tbl_rbusy1(tbl_rbusy1), .tbl_rbusy2(tbl_rbusy2), .tbl_rbusy3(tbl_rbusy3),
    .tbl_waddr0(tbl_waddr0), .tbl_waddr1(tbl_waddr1), .tbl_wen0(tbl_wen0), .tbl_wen1(tbl_wen1),
    .tbl_wnum0(tbl_wnum0), .tbl_wnum1(tbl_wnum1), .commit_cnt(commit_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_v1(out_v1),
    .out_rob0(out_rob0), .out_rob1(out_rob1),
    .out_num0a(out_num0a), .out_num0b(out_num0b), .out_num1a(out_num1a), .out_num1b(out_num1b),
    .out_busy0a(out_busy0a), .out_busy0b(out_busy0b), .out_busy1a(out_busy1a), .out_busy1b(out_busy1b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [ROB_W:0] resolve(input logic [GPR_W-1:0] s, input logic hit,
                                             input logic [ROB_W-1:0] r0);
    if (s == '0) return '0;
    if (hit) return {1'b1, r0};
    return {tbusy[s], tnum[s]};
  endfunction

  task automatic model_reset();
    tail_m = 0;
    rob_q.delete();
    ov_m = 1'b0; v1_m = 1'b0; m_rob0 = '0; m_rob1 = '0;
    for (int i = 0; i < 4; i++) m_src[i] = '0;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, ov_m);
    if (ov_m) begin
      check_eq("out_v1", out_v1, v1_m);
      check_eq("out_rob0", out_rob0, m_rob0);
      check_eq("src0a", {out_busy0a, out_num0a}, m_src[0]);
      check_eq("src0b", {out_busy0b, out_num0b}, m_src[1]);
      if (v1_m) begin
        check_eq("out_rob1", out_rob1, m_rob1);
        check_eq("src1a", {out_busy1a, out_num1a}, m_src[2]);
        check_eq("src1b", {out_busy1b, out_num1b}, m_src[3]);
      end
    end
  endtask

  // Inputs are set at the falling edge before this is called.
  task automatic step();
    int free_m, idx;
    logic stg, w0, w1, h1a, h1b, dep, e0, e1;
    logic [ROB_W-1:0] r0, r1;
    logic [ROB_W:0] s[4];
    #1;
    free_m = ROB_SIZE - rob_q.size();
    stg = !ov_m || out_ready;
    w0  = in_wen0 && (in_dst0 != 0);
    w1  = in_wen1 && (in_dst1 != 0);
    h1a = w0 && (in_src1a != 0) && (in_src1a == in_dst0);
    h1b = w0 && (in_src1b != 0) && (in_src1b == in_dst0);
    dep = BYP || !(h1a || h1b);
    e0  = in_valid0 && stg && (free_m >= 1) && !flush;
    e1  = e0 && in_valid1 && (free_m >= 2) && dep;
    r0  = ROB_W'(tail_m);
    r1  = ROB_W'((tail_m + 1) % ROB_SIZE);
    check_eq("in_acc0", in_acc0, e0);
    check_eq("in_acc1", in_acc1, e1);
    check_eq("raddr", {tbl_raddr0, tbl_raddr1, tbl_raddr2, tbl_raddr3},
             {in_src0a, in_src0b, in_src1a, in_src1b});
    check_eq("tbl_wen0", tbl_wen0, e0 && w0);
    check_eq("tbl_wen1", tbl_wen1, e1 && w1);
    if (e0 && w0) check_eq("tbl_w0", {tbl_waddr0, tbl_wnum0}, {in_dst0, r0});
    if (e1 && w1) check_eq("tbl_w1", {tbl_waddr1, tbl_wnum1}, {in_dst1, r1});
    s[0] = resolve(in_src0a, 1'b0, r0);
    s[1] = resolve(in_src0b, 1'b0, r0);
    s[2] = resolve(in_src1a, BYP && h1a, r0);
    s[3] = resolve(in_src1b, BYP && h1b, r0);
    @(posedge clk);
    #1;
    if (flush) begin
      tail_m = 0;
      rob_q.delete();
      ov_m = 1'b0;
    end else begin
      for (int i = 0; i < int'(commit_cnt); i++) rob_q.delete(0);
      if (e0) rob_q.push_back(int'(r0));
      if (e1) rob_q.push_back(int'(r1));
      tail_m = (tail_m + int'(e0) + int'(e1)) % ROB_SIZE;
      if (e0) begin
        ov_m = 1'b1; v1_m = e1; m_rob0 = r0; m_rob1 = r1;
        for (int i = 0; i < 4; i++) m_src[i] = s[i];
      end else if (out_ready) begin
        ov_m = 1'b0;
      end
      if (e0 && w0) begin tbusy[in_dst0] = 1'b1; tnum[in_dst0] = r0; end
      if (e1 && w1) begin tbusy[in_dst1] = 1'b1; tnum[in_dst1] = r1; end
    end
    if ($urandom % 3 == 0) begin
      idx = $urandom_range(1, 7);
      tbusy[idx] = 1'b0;
    end
    check_outputs();
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int commit_pct, input int flush_pct);
    int cmax;
    in_valid0 = ($urandom % 8) != 0;
    in_valid1 = in_valid0 && (($urandom % 4) != 0);
    in_src0a = GPR_W'($urandom_range(0, 7));
    in_src0b = GPR_W'($urandom_range(0, 7));
    in_src1a = GPR_W'($urandom_range(0, 7));
    in_src1b = GPR_W'($urandom_range(0, 7));
    in_dst0  = GPR_W'($urandom_range(0, 7));
    in_dst1  = GPR_W'($urandom_range(0, 7));
    in_wen0  = ($urandom % 5) != 0;
    in_wen1  = ($urandom % 5) != 0;
    out_ready = ($urandom % 4) != 0;
    flush = int'($urandom % 100) < flush_pct;
    cmax = (rob_q.size() < 2) ? rob_q.size() : 2;
    commit_cnt = (int'($urandom % 100) < commit_pct) ? 2'($urandom_range(0, cmax)) : 2'd0;
  endtask

  task automatic idle_inputs();
    {in_valid0, in_valid1, in_wen0, in_wen1, flush} = '0;
    {in_src0a, in_src0b, in_src1a, in_src1b, in_dst0, in_dst1} = '0;
    commit_cnt = 2'd0;
    out_ready  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_GPR; i++) begin tnum[i] = '0; tbusy[i] = 1'b0; end
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_rob0", out_rob0, '0);
    check_eq("rst_tbl_wen0", tbl_wen0, 1'b0);
    reset = 1'b0;

    // Single instruction into an idle table.
    in_valid0 = 1'b1; in_src0a = 5'd3; in_src0b = 5'd4; in_dst0 = 5'd5; in_wen0 = 1'b1;
    step();
    // Dependent pair: slot 1 reads slot 0's destination.
    in_valid1 = 1'b1; in_src0a = 5'd1; in_src0b = 5'd0; in_src1a = 5'd5; in_src1b = 5'd2;
    in_dst1 = 5'd6; in_wen1 = 1'b1;
    step();
    step();

    for (int n = 0; n < 400; n++) begin rand_inputs(15, 2); step(); end

    // Asynchronous reset between edges drops the output register at once.
    idle_inputs();
    in_valid0 = 1'b1;
    step();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_v1", out_v1, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin rand_inputs(90, 3); step(); end
    for (int n = 0; n < 400; n++) begin rand_inputs(40, 1); step(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
